// File: rtl/div_pkg.sv
// Shared definitions for the divide/modulo execute-stage controller.
package div_pkg;

    typedef logic [31:0] word_t;

    localparam logic [1:0] DIV_W  = 2'b00;
    localparam logic [1:0] MOD_W  = 2'b01;
    localparam logic [1:0] DIV_WU = 2'b10;
    localparam logic [1:0] MOD_WU = 2'b11;

    localparam word_t INT_MIN  = 32'h8000_0000;
    localparam word_t ALL_ONES = 32'hffff_ffff;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait,
        StDone
    } state_e;

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == DIV_W) || (op == MOD_W);
    endfunction

    function automatic logic is_mod_op(input logic [1:0] op);
        return (op == MOD_W) || (op == MOD_WU);
    endfunction

endpackage

// File: rtl/div_result_cache.sv
// Single-entry cache of the last divider result, tagged by operands and signedness.
module div_result_cache
    import div_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  wr_en,
    input  word_t wr_dividend,
    input  word_t wr_divisor,
    input  logic  wr_sign,
    input  word_t wr_quotient,
    input  word_t wr_remainder,
    input  word_t lookup_dividend,
    input  word_t lookup_divisor,
    input  logic  lookup_sign,
    output logic  hit,
    output word_t quotient,
    output word_t remainder
);

    logic  valid_q;
    word_t dividend_q;
    word_t divisor_q;
    logic  sign_q;
    word_t quotient_q;
    word_t remainder_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            sign_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else if (wr_en) begin
            valid_q     <= 1'b1;
            dividend_q  <= wr_dividend;
            divisor_q   <= wr_divisor;
            sign_q      <= wr_sign;
            quotient_q  <= wr_quotient;
            remainder_q <= wr_remainder;
        end
    end

    always_comb begin
        hit = valid_q && (dividend_q == lookup_dividend) && (divisor_q == lookup_divisor)
              && (sign_q == lookup_sign);
        quotient  = quotient_q;
        remainder = remainder_q;
    end

endmodule

// File: rtl/div_ctrl.sv
// EX-stage control for div/mod: bypasses trivial cases, sequences the divider, holds the result.
module div_ctrl
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [1:0]  op_code,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    input  logic        ex_advance,
    output logic        ex_stall,
    output logic        res_valid,
    output logic [31:0] res,
    output logic        div_en,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    output logic        div_sign,
    output logic        div_flush,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder,
    input  logic        div_ready
);

    state_e state_q, state_d;

    logic [1:0] op_q;
    word_t      dividend_q;
    word_t      divisor_q;
    logic       sign_q;
    word_t      quot_q;
    word_t      rem_q;

    logic  req_sign;
    logic  accept;
    logic  capture;
    logic  bypass;
    word_t byp_quot;
    word_t byp_rem;
    logic  cache_hit;
    word_t cache_quot;
    word_t cache_rem;

    assign req_sign = is_signed_op(op_code);

    div_result_cache u_cache (
        .clk             (clk),
        .rst             (rst),
        .wr_en           (capture),
        .wr_dividend     (dividend_q),
        .wr_divisor      (divisor_q),
        .wr_sign         (sign_q),
        .wr_quotient     (div_quotient),
        .wr_remainder    (div_remainder),
        .lookup_dividend (src1),
        .lookup_divisor  (src2),
        .lookup_sign     (req_sign),
        .hit             (cache_hit),
        .quotient        (cache_quot),
        .remainder       (cache_rem)
    );

    // Bypass priority: divide-by-zero, then signed overflow, then cache hit.
    always_comb begin
        bypass   = 1'b1;
        byp_quot = cache_quot;
        byp_rem  = cache_rem;
        if (src2 == '0) begin
            byp_quot = ALL_ONES;
            byp_rem  = src1;
        end else if (req_sign && (src1 == INT_MIN) && (src2 == ALL_ONES)) begin
            byp_quot = INT_MIN;
            byp_rem  = '0;
        end else if (!cache_hit) begin
            bypass = 1'b0;
        end
    end

    assign accept  = (state_q == StIdle) && op_valid && !flush;
    assign capture = (state_q == StWait) && div_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (op_valid) state_d = bypass ? StDone : StStart;
                StStart: state_d = StWait;
                StWait:  if (div_ready) state_d = StDone;
                StDone:  if (ex_advance) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= DIV_W;
            dividend_q <= '0;
            divisor_q  <= '0;
            sign_q     <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
        end else if (accept) begin
            op_q       <= op_code;
            dividend_q <= src1;
            divisor_q  <= src2;
            sign_q     <= req_sign;
            if (bypass) begin
                quot_q <= byp_quot;
                rem_q  <= byp_rem;
            end
        end else if (capture) begin
            quot_q <= div_quotient;
            rem_q  <= div_remainder;
        end
    end

    always_comb begin
        ex_stall     = op_valid && (state_q != StDone);
        res_valid    = (state_q == StDone);
        res          = '0;
        if (res_valid) begin
            res = is_mod_op(op_q) ? rem_q : quot_q;
        end
        div_en       = (state_q == StStart) && !flush;
        div_flush    = flush && ((state_q == StStart) || (state_q == StWait));
        div_dividend = dividend_q;
        div_divisor  = divisor_q;
        div_sign     = sign_q;
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed scoreboard bench for div_ctrl with a fixed-latency behavioural divider.
module tb_div_ctrl;
    import div_pkg::*;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [1:0]  op_code;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        ex_advance;
    logic        ex_stall;
    logic        res_valid;
    logic [31:0] res;
    logic        div_en;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_sign;
    logic        div_flush;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic        div_ready;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    div_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .op_valid      (op_valid),
        .op_code       (op_code),
        .src1          (src1),
        .src2          (src2),
        .flush         (flush),
        .ex_advance    (ex_advance),
        .ex_stall      (ex_stall),
        .res_valid     (res_valid),
        .res           (res),
        .div_en        (div_en),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_sign      (div_sign),
        .div_flush     (div_flush),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .div_ready     (div_ready)
    );

    // Behavioural divider: div_ready arrives LAT cycles after the div_en cycle.
    logic        busy;
    int          cnt;
    logic [31:0] m_q;
    logic [31:0] m_r;

    always @(posedge clk) begin
        div_ready <= 1'b0;
        if (rst || div_flush) begin
            busy <= 1'b0;
        end else if (div_en) begin
            busy <= 1'b1;
            cnt  <= LAT - 1;
            if (div_divisor == 32'd0) begin
                m_q <= 32'hffff_ffff;
                m_r <= div_dividend;
            end else if (div_sign) begin
                m_q <= $signed(div_dividend) / $signed(div_divisor);
                m_r <= $signed(div_dividend) % $signed(div_divisor);
            end else begin
                m_q <= div_dividend / div_divisor;
                m_r <= div_dividend % div_divisor;
            end
        end else if (busy) begin
            if (cnt == 1) begin
                div_ready     <= 1'b1;
                div_quotient  <= m_q;
                div_remainder <= m_r;
                busy          <= 1'b0;
            end
            cnt <= cnt - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Monitor: each new result presentation is compared against the oldest expectation.
    initial begin
        logic prev_rv;
        logic [31:0] want;
        prev_rv = 1'b0;
        forever begin
            @(negedge clk);
            if (res_valid === 1'b1 && !prev_rv) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_result: got %h, want none", res);
                end else begin
                    want = exp_q.pop_front();
                    check("scoreboard_res", res, want);
                end
            end
            prev_rv = (res_valid === 1'b1);
        end
    end

    task automatic do_op(input string name, input logic [1:0] code, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_en,
                         input int exp_stall, input int hold, input bit adv);
        int stalls;
        int ens;
        int cyc;
        logic [31:0] cap_a;
        logic [31:0] cap_b;
        logic cap_s;
        exp_q.push_back(exp);
        @(negedge clk);
        op_valid   = 1'b1;
        op_code    = code;
        src1       = a;
        src2       = b;
        ex_advance = 1'b0;
        stalls     = 0;
        ens        = 0;
        cyc        = 0;
        cap_a      = 'x;
        cap_b      = 'x;
        cap_s      = 1'bx;
        #1;
        while (res_valid !== 1'b1 && cyc < 100) begin
            if (ex_stall) stalls++;
            if (div_en) begin
                ens++;
                cap_a = div_dividend;
                cap_b = div_divisor;
                cap_s = div_sign;
            end
            cyc++;
            @(negedge clk);
            #1;
        end
        check({name, "_reached_done"}, {31'd0, res_valid}, 32'd1);
        check({name, "_stall_cycles"}, stalls, exp_stall);
        check({name, "_div_en_count"}, ens, exp_en);
        if (exp_en > 0) begin
            check({name, "_div_dividend"}, cap_a, a);
            check({name, "_div_divisor"}, cap_b, b);
            check({name, "_div_sign"}, {31'd0, cap_s}, {31'd0, ~code[1]});
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            check({name, "_held_res"}, res, exp);
            check({name, "_held_valid"}, {31'd0, res_valid}, 32'd1);
            check({name, "_held_no_div_en"}, {31'd0, div_en}, 32'd0);
            check({name, "_held_no_stall"}, {31'd0, ex_stall}, 32'd0);
        end
        if (adv) begin
            ex_advance = 1'b1;
            @(negedge clk);
            op_valid   = 1'b0;
            ex_advance = 1'b0;
            #1;
            check({name, "_back_idle"}, {31'd0, res_valid}, 32'd0);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ex_stall"}, {31'd0, ex_stall}, 32'd0);
        check({name, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        check({name, "_res"}, res, 32'd0);
        check({name, "_div_en"}, {31'd0, div_en}, 32'd0);
        check({name, "_div_dividend"}, div_dividend, 32'd0);
        check({name, "_div_divisor"}, div_divisor, 32'd0);
        check({name, "_div_sign"}, {31'd0, div_sign}, 32'd0);
        check({name, "_div_flush"}, {31'd0, div_flush}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        rst        = 1'b1;
        op_valid   = 1'b0;
        op_code    = DIV_W;
        src1       = '0;
        src2       = '0;
        flush      = 1'b0;
        ex_advance = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        do_op("divwu_9_3", DIV_WU, 32'd9, 32'd3, 32'd3, 1, LAT + 2, 0, 1);
        do_op("divw_m7_2", DIV_W, 32'hffff_fff9, 32'd2, 32'hffff_fffd, 1, LAT + 2, 0, 1);
        do_op("modw_m7_2_hit", MOD_W, 32'hffff_fff9, 32'd2, 32'hffff_ffff, 0, 1, 0, 1);
        do_op("divw_by0", DIV_W, 32'd5, 32'd0, 32'hffff_ffff, 0, 1, 0, 1);
        do_op("modw_by0", MOD_W, 32'd5, 32'd0, 32'd5, 0, 1, 0, 1);
        do_op("divw_ovf", DIV_W, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 0, 1, 0, 1);
        do_op("modw_ovf", MOD_W, 32'h8000_0000, 32'hffff_ffff, 32'd0, 0, 1, 0, 1);
        do_op("modwu_nonovf", MOD_WU, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 1,
              LAT + 2, 0, 1);

        // Flush landing in the same cycle as div_ready.
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = DIV_WU;
        src1     = 32'd100;
        src2     = 32'd7;
        cyc      = 0;
        while (div_ready !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("flush_ready_seen", {31'd0, div_ready}, 32'd1);
        flush = 1'b1;
        #1;
        check("flush_div_flush", {31'd0, div_flush}, 32'd1);
        @(negedge clk);
        flush    = 1'b0;
        op_valid = 1'b0;
        #1;
        check("flush_no_res_valid", {31'd0, res_valid}, 32'd0);
        check("flush_div_flush_drop", {31'd0, div_flush}, 32'd0);
        @(negedge clk);
        #1;
        check("flush_still_idle", {31'd0, res_valid}, 32'd0);

        do_op("divwu_reissue", DIV_WU, 32'd100, 32'd7, 32'd14, 1, LAT + 2, 0, 1);
        do_op("modwu_held", MOD_WU, 32'd100, 32'd7, 32'd2, 0, 1, 3, 1);

        // Reset while parked in DONE.
        do_op("divw_pre_rst", DIV_W, 32'd5, 32'd0, 32'hffff_ffff, 0, 1, 1, 0);
        rst      = 1'b1;
        op_valid = 1'b0;
        @(negedge clk);
        #1;
        check_all_zero("rst_pulse");
        rst = 1'b0;

        do_op("divwu_post_rst", DIV_WU, 32'd100, 32'd7, 32'd14, 1, LAT + 2, 0, 1);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
